// File: rtl/serial_comp_ctrl.sv
// Bit-serial unsigned magnitude comparator controller.
// Latches two WIDTH-bit operands and walks them MSB-first one bit per clock.
// The first differing bit decides the result. The result is reported as
// gt/eq/lt through a start/busy/done handshake.
module serial_comp_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               decided_q, decided_d;
  logic               g_q, g_d;
  logic               done_q, done_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;

  // The current bit pair differs.
  logic mismatch;
  assign mismatch = sa_q[WIDTH-1] ^ sb_q[WIDTH-1];

  // Next-state and datapath update. Defaults hold every register, and done is a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    g_d       = g_q;
    done_d    = 1'b0;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    unique case (state_q)
      S_IDLE: begin
        // Start takes priority over abort here. Abort has no meaning in IDLE.
        if (start) begin
          sa_d      = a;
          sb_d      = b;
          cnt_d     = CNT_W'(WIDTH - 1);
          decided_d = 1'b0;
          g_d       = 1'b0;
          gt_d      = 1'b0;
          eq_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sa_d  = {sa_q[WIDTH-2:0], 1'b0};
        sb_d  = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        // Only the most significant differing bit counts.
        if (mismatch && !decided_q) begin
          decided_d = 1'b1;
          g_d       = sa_q[WIDTH-1];
        end
        if (abort) begin
          // Cancelled compares leave all flags cleared and produce no done pulse.
          state_d = S_IDLE;
        end else if ((EARLY_EXIT && mismatch) || (cnt_q == '0)) begin
          // Fold in this edge's decision so the flags are valid with done.
          state_d = S_DONE;
          done_d  = 1'b1;
          gt_d    = decided_d & g_d;
          lt_d    = decided_d & ~g_d;
          eq_d    = ~decided_d;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      g_q       <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      g_q       <= g_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed bench for serial_comp_ctrl (WIDTH=8).
// One instance exits early on the first differing bit, and one always scans all 8 bits.
// Both instances see identical stimulus.
module tb_serial_comp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] a;
  logic [7:0] b;

  logic busy1, done1, gt1, eq1, lt1;
  logic busy0, done0, gt0, eq0, lt0;

  serial_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a(a), .b(b),
    .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
  );

  serial_comp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a(a), .b(b),
    .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observations per instance. Index 0 is the early-exit instance, and index 1 is the full-scan instance.
  int         dc[2];
  int         nd[2];
  int         bc[2];
  logic [2:0] f1[2];
  logic [2:0] fd[2];

  function automatic logic [2:0] flags(input int i);
    return (i == 0) ? {gt1, eq1, lt1} : {gt0, eq0, lt0};
  endfunction

  function automatic logic bsy(input int i);
    return (i == 0) ? busy1 : busy0;
  endfunction

  function automatic logic dn(input int i);
    return (i == 0) ? done1 : done0;
  endfunction

  // Accept a start at edge 0, then observe cycles 1..20 on falling edges.
  // inj_kind 1 pulses start with a=0xFF in cycle inj_cyc.
  // inj_kind 2 pulses abort in cycle inj_cyc.
  task automatic run(input logic [7:0] av, input logic [7:0] bv,
                     input int inj_cyc, input int inj_kind);
    @(negedge clk);
    a = av; b = bv; start = 1'b1; abort = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      dc[i] = 0; nd[i] = 0; bc[i] = 0; f1[i] = '0; fd[i] = '0;
    end
    for (int c = 1; c <= 20; c++) begin
      start = 1'b0;
      abort = 1'b0;
      if (c == inj_cyc && inj_kind == 1) begin
        start = 1'b1;
        a     = 8'hFF;
      end
      if (c == inj_cyc && inj_kind == 2) abort = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (bsy(i)) bc[i]++;
        if (c == 1) f1[i] = flags(i);
        if (dn(i)) begin
          nd[i]++;
          if (dc[i] == 0) dc[i] = c;
          fd[i] = flags(i);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  // exp_fl is {gt,eq,lt}. A done cycle of 0 means no done pulse is expected.
  task automatic expect_run(input string tag, input int dc1, input int dc0,
                            input int bc1, input int bc0, input logic [2:0] exp_fl);
    int edc[2];
    int ebc[2];
    edc[0] = dc1; edc[1] = dc0;
    ebc[0] = bc1; ebc[1] = bc0;
    for (int i = 0; i < 2; i++) begin
      string s;
      s = (i == 0) ? {tag, "/ee1"} : {tag, "/ee0"};
      check({s, " done_cycle"}, dc[i], edc[i]);
      check({s, " done_pulses"}, nd[i], (edc[i] != 0) ? 1 : 0);
      check({s, " busy_cycles"}, bc[i], ebc[i]);
      check({s, " flags_while_busy"}, f1[i], 3'b000);
      if (edc[i] != 0) check({s, " flags_at_done"}, fd[i], exp_fl);
      check({s, " flags_held"}, flags(i), exp_fl);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset busy", bsy(i), 1'b0);
      check("reset done", dn(i), 1'b0);
      check("reset flags", flags(i), 3'b000);
    end
    rst = 1'b0;

    // Equal operands scan all bits.
    run(8'hA5, 8'hA5, 0, 0);
    expect_run("eq_A5", 9, 9, 9, 9, 3'b010);

    // MSB decides. Early exit finishes after one compare edge.
    run(8'h80, 8'h7F, 0, 0);
    expect_run("gt_msb", 2, 9, 2, 9, 3'b100);

    // LSB decides. Both instances take the full scan.
    run(8'h3C, 8'h3D, 0, 0);
    expect_run("lt_lsb", 9, 9, 9, 9, 3'b001);

    // Bit 5 decides (0x10 < 0x20). The restart with a=0xFF while busy is ignored.
    // The early-exit instance finishes in cycle 8-5+1=4.
    run(8'h10, 8'h20, 1, 1);
    expect_run("busy_start", 4, 9, 4, 9, 3'b001);

    // Abort sampled at edge 3 means busy in cycles 1..3, with no done and cleared flags.
    run(8'h55, 8'h55, 3, 2);
    expect_run("abort", 0, 0, 3, 3, 3'b000);
    run(8'h55, 8'h55, 0, 0);
    expect_run("after_abort", 9, 9, 9, 9, 3'b010);

    // Reset while idle clears the held result.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_rst flags ee1", flags(0), 3'b000);
    check("idle_rst flags ee0", flags(1), 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a compare.
    @(negedge clk);
    a = 8'h55; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid busy_before ee1", busy1, 1'b1);
    check("mid busy_before ee0", busy0, 1'b1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("mid_rst busy", bsy(i), 1'b0);
      check("mid_rst done", dn(i), 1'b0);
      check("mid_rst flags", flags(i), 3'b000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst idle ee1", busy1, 1'b0);
    check("post_rst idle ee0", busy0, 1'b0);
    run(8'h01, 8'h00, 0, 0);
    expect_run("post_rst_gt", 9, 9, 9, 9, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
